// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched instruction as valid,
// squash clears only the valid flag, otherwise everything holds.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        squash_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // Capture on load; squash drops valid but keeps the stale fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (squash_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALT control, redirect and IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned MEM_WORDS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] cnt_busca,
  output logic [31:0] cnt_stall,
`endif
  output logic        erro_alinh
);

  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         halted_q;
  logic         erro_q;
  logic         load_d;
  logic         squash_d;
  logic [31:0]  target_w;
  logic [31:0]  pc4_w;

  assign target_w = {alvo_desvio[31:2], 2'b00};
  assign pc4_w    = pc_q + 32'd4;

  // IF/ID control: redirect or end-of-program squash, else load when not stalled.
  always_comb begin
    load_d   = 1'b0;
    squash_d = 1'b0;
    if (state_q == FS_RUN) begin
      if (desvio)                squash_d = 1'b1;
      else if (!stall && pc_q < LIMIT) load_d = 1'b1;
      else if (!stall)           squash_d = 1'b1;
    end
  end

  // PC and RUN/HALT FSM with registered halted / misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      erro_q <= 1'b0;
      case (state_q)
        FS_RUN: begin
          if (desvio) begin
            pc_q   <= target_w;
            erro_q <= |alvo_desvio[1:0];
          end else if (!stall) begin
            if (pc_q < LIMIT) begin
              pc_q <= pc4_w;
            end else begin
              state_q  <= FS_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        FS_HALT: begin
          if (desvio) begin
            state_q  <= FS_RUN;
            halted_q <= 1'b0;
            pc_q     <= target_w;
            erro_q   <= |alvo_desvio[1:0];
          end
        end
        default: state_q <= FS_RUN;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_d),
    .squash_i (squash_d),
    .instr_i  (instrucao),
    .pc_i     (pc_q),
    .pc4_i    (pc4_w),
    .instr_o  (if_id_instr),
    .pc_o     (if_id_pc),
    .pc4_o    (if_id_pc4),
    .valid_o  (if_id_valid)
  );

  assign endereco   = pc_q;
  assign halted     = halted_q;
  assign erro_alinh = erro_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_busca_q;
  logic [31:0] cnt_stall_q;

  // Saturating counters of valid IF/ID loads and RUN-state stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_busca_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (load_d && cnt_busca_q != '1)
        cnt_busca_q <= cnt_busca_q + 32'd1;
      if (state_q == FS_RUN && stall && !desvio && cnt_stall_q != '1)
        cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign cnt_busca = cnt_busca_q;
  assign cnt_stall = cnt_stall_q;
`endif

endmodule
